// File: rtl/div_restoring_16.sv
// div_restoring_16 -- multi-cycle unsigned restoring divider.
//
// Divides a WIDTH-bit dividend by a WIDTH-bit divisor and returns the
// quotient and remainder. Each clock performs one restoring iteration,
// one trial subtraction per quotient bit. Valid/ready handshakes on both
// sides let the execute stage stall on the divider.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   in_valid     operands present
//   in_ready     divider can accept operands (IDLE only)
//   dividend     unsigned numerator, sampled on accept
//   divisor      unsigned denominator, sampled on accept
//   out_valid    quotient/remainder valid (DONE only)
//   out_ready    consumer takes the result
//   quotient     unsigned quotient
//   remainder    unsigned remainder
//   div_by_zero  result came from a zero divisor
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for operands; in_ready high
// BUSY  | one restoring iteration per clock, WIDTH iterations in total
// DONE  | result held stable with out_valid high until out_ready

module div_restoring_16 #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    // Partial remainder shifted left with the next dividend bit. The dropped
    // rem_q MSB is always zero before it is shifted out: after k iterations
    // the partial remainder is below 2^k, so r' always fits in WIDTH bits.
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH:0]   trial;
    logic             borrow;

    assign r_shift = {rem_q[WIDTH-2:0], shift_q[WIDTH-1]};
    assign trial   = {1'b0, r_shift} - {1'b0, div_q};
    assign borrow  = trial[WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            shift_q <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            shift_q <= shift_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        shift_d = shift_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (divisor == '0) begin
                        // No iterations needed: publish the saturated result
                        // right away.
                        quot_d  = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        div_d   = divisor;
                        shift_d = dividend;
                        rem_d   = '0;
                        quot_d  = '0;
                        cnt_d   = '0;
                        dbz_d   = 1'b0;
                        state_d = S_BUSY;
                    end
                end
            end

            S_BUSY: begin
                shift_d = {shift_q[WIDTH-2:0], 1'b0};
                rem_d   = borrow ? r_shift : trial[WIDTH-1:0];
                quot_d  = {quot_q[WIDTH-2:0], ~borrow};
                cnt_d   = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    dbz_d   = 1'b0;
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_restoring_16.sv
module tb_div_restoring_16;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    div_restoring_16 #(.WIDTH(16), .CNT_W(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] n;
        logic [15:0] d;
        logic [15:0] q;
        logic [15:0] r;
        logic        z;
    } vec_t;

    vec_t vecs[12];

    int n_chk  = 0;
    int n_fail = 0;
    int acc_cnt = 0;
    int res_cnt = 0;

    // Handshakes are counted on the falling edge: inputs are driven just
    // after the rising edge, so they are settled for the next rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready)   acc_cnt++;
            if (out_valid && out_ready) res_cnt++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for in_ready, present operands for one accept edge, then scramble
    // the operand inputs to show they are not re-sampled.
    task automatic start_op(input logic [15:0] n, input logic [15:0] d);
        int guard = 0;
        while (!in_ready && guard < 100) begin
            tick();
            guard++;
        end
        if (guard >= 100) chk("in_ready_timeout", 32'd0, 32'd1);
        in_valid = 1'b1;
        dividend = n;
        divisor  = d;
        tick();
        in_valid = 1'b0;
        dividend = 16'($urandom);
        divisor  = 16'($urandom);
    endtask

    // Edges counted after the accept edge until out_valid is seen; a
    // divide-by-zero result is already valid in the cycle following the
    // accept edge, giving 0 here.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        if (lat >= 100) chk("out_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input int hold);
        int lat;
        out_ready = 1'b0;
        start_op(v.n, v.d);
        wait_valid(lat);
        chk("latency", 32'(lat), v.z ? 32'd0 : 32'd16);
        chk("quotient", 32'(quotient), 32'(v.q));
        chk("remainder", 32'(remainder), 32'(v.r));
        chk("div_by_zero", 32'(div_by_zero), 32'(v.z));
        chk("in_ready_done", 32'(in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_q", 32'(quotient), 32'(v.q));
            chk("hold_r", 32'(remainder), 32'(v.r));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("drain_valid", 32'(out_valid), 32'd0);
        chk("drain_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        int acc0, res0;
        logic [15:0] rn, rd;
        logic [31:0] prod;

        vecs[0]  = '{16'd100,   16'd7,      16'd14,     16'd2,      1'b0};
        vecs[1]  = '{16'hFFFF,  16'h0001,   16'hFFFF,   16'h0000,   1'b0};
        vecs[2]  = '{16'hFFFF,  16'hFFFF,   16'h0001,   16'h0000,   1'b0};
        vecs[3]  = '{16'd5,     16'd9,      16'd0,      16'd5,      1'b0};
        vecs[4]  = '{16'h1234,  16'h0000,   16'hFFFF,   16'h1234,   1'b1};
        vecs[5]  = '{16'd0,     16'd5,      16'd0,      16'd0,      1'b0};
        vecs[6]  = '{16'd1000,  16'd33,     16'd30,     16'd10,     1'b0};
        vecs[7]  = '{16'd40000, 16'd200,    16'd200,    16'd0,      1'b0};
        vecs[8]  = '{16'h8000,  16'h8001,   16'h0000,   16'h8000,   1'b0};
        vecs[9]  = '{16'hFFFF,  16'h8000,   16'h0001,   16'h7FFF,   1'b0};
        vecs[10] = '{16'd65535, 16'd255,    16'd257,    16'd0,      1'b0};
        vecs[11] = '{16'd0,     16'd0,      16'hFFFF,   16'd0,      1'b1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_q", 32'(quotient), 32'd0);
        chk("reset_r", 32'(remainder), 32'd0);
        chk("reset_dbz", 32'(div_by_zero), 32'd0);

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i], i % 3);
        end

        // Backpressure with stray in_valid pulses during BUSY and DONE.
        out_ready = 1'b0;
        start_op(16'd1000, 16'd33);
        in_valid = 1'b1;
        dividend = 16'd7;
        divisor  = 16'd1;
        wait_valid(lat);
        chk("bp_latency", 32'(lat), 32'd16);
        for (int i = 0; i < 10; i++) begin
            chk("bp_q", 32'(quotient), 32'd30);
            chk("bp_r", 32'(remainder), 32'd10);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_drain_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("bp_no_second", 32'(out_valid), 32'd0);
        end
        out_ready = 1'b0;

        // Asynchronous reset 5 cycles into BUSY.
        start_op(16'd1000, 16'd33);
        repeat (5) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_q", 32'(quotient), 32'd0);
        chk("arst_r", 32'(remainder), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        run_vec(vecs[7], 0);

        // Random back-to-back operands with random backpressure.
        acc0 = acc_cnt;
        res0 = res_cnt;
        for (int k = 0; k < 40; k++) begin
            rn = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       rd = 16'($urandom_range(1, 15));
                1:       rd = 16'($urandom_range(1, 65535));
                2:       rd = 16'd0;
                default: rd = 16'($urandom_range(1, 255));
            endcase
            out_ready = 1'b0;
            start_op(rn, rd);
            wait_valid(lat);
            repeat ($urandom_range(0, 3)) tick();
            if (rd == 16'd0) begin
                chk("rand_dbz_q", 32'(quotient), 32'hFFFF);
                chk("rand_dbz_r", 32'(remainder), 32'(rn));
                chk("rand_dbz_flag", 32'(div_by_zero), 32'd1);
            end else begin
                prod = 32'(quotient) * 32'(rd) + 32'(remainder);
                chk("rand_invariant", prod, 32'(rn));
                chk("rand_r_lt_d", 32'(remainder < rd), 32'd1);
                chk("rand_dbz_clear", 32'(div_by_zero), 32'd0);
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        repeat (2) tick();
        chk("rand_counts", 32'(res_cnt - res0), 32'(acc_cnt - acc0));
        chk("rand_accepts", 32'(acc_cnt - acc0), 32'd40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
